bilbo_bist_ctl: RTL and testbench

BIST sequencer that drives one `bilbo_generic`-style datapath register chain from the test side. It serially loads a seed through the register's scan input and holds the register in LFSR/MISR mode for a fixed pattern count. It then shifts the signature back out through the register's scan output and compares it against a golden value. It sits in the test-control area beside the datapath and is the scan master for the BILBO's `SDI` and serial-out pins.

---
 rtl/bist_pkg.sv | 14 +
 rtl/bist_cnt.sv | 20 ++
 rtl/bilbo_bist_ctl.sv | 75 +++++++
 tb/tb_bilbo_bist_ctl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: sequencer states, BILBO mode codes and counter-width helper
package bist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_UNLOAD, S_DONE} state_t;
  localparam logic [1:0] MODE_NORM  = 2'b11;
  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_LFSR  = 2'b10;
  localparam logic [1:0] MODE_RST   = 2'b01;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/bist_cnt.sv
// bist_cnt: loadable down-counter with zero flag
// Ports: CLK clock, CLR async active-low clear, ld/ld_val load, dec decrement, cnt value, zero cnt==0
module bist_cnt #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (dec) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/bilbo_bist_ctl.sv
// bilbo_bist_ctl: BIST sequencer that seeds, runs and unloads one BILBO register chain
// Ports: CLK clock, CLR async active-low reset, START launch a test (IDLE/DONE only),
//   SDO chain serial out, B1/B2 BILBO mode, SDI chain serial in, BUSY test in progress,
//   DONE test finished, PASS signature matched GOLD, SIG captured signature
module bilbo_bist_ctl
  import bist_pkg::*;
#(
  parameter int           N    = 8,
  parameter int           NPAT = 255,
  parameter logic [N-1:0] SEED = 8'h01,
  parameter logic [N-1:0] GOLD = 8'h00
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         START,
  input  logic         SDO,
  output logic         B1,
  output logic         B2,
  output logic         SDI,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS,
  output logic [N-1:0] SIG
);
  localparam int CW = clog2(N > NPAT ? N : NPAT);
  state_t state, nxt;
  logic ld, dec, zero;
  logic [CW-1:0] ld_val, cnt;
  logic [N-1:0] sig_nxt;
  bist_cnt #(.W(CW)) u_cnt (
    .CLK(CLK),
    .CLR(CLR),
    .ld(ld),
    .ld_val(ld_val),
    .dec(dec),
    .cnt(cnt),
    .zero(zero)
  );
  always_comb begin
    nxt = state;
    ld = 1'b0;
    dec = 1'b0;
    ld_val = CW'(N - 1);
    case (state)
      S_IDLE, S_DONE: if (START) begin nxt = S_SEED; ld = 1'b1; end
      S_SEED: if (zero) begin nxt = S_RUN; ld = 1'b1; ld_val = CW'(NPAT - 1); end else dec = 1'b1;
      S_RUN: if (zero) begin nxt = S_UNLOAD; ld = 1'b1; end else dec = 1'b1;
      S_UNLOAD: if (zero) nxt = S_DONE; else dec = 1'b1;
      default: nxt = S_IDLE;
    endcase
  end
  // Illegal state encodings put the chain into its reset mode.
  assign {B1, B2} = state == S_RUN ? MODE_LFSR :
                    (state == S_SEED || state == S_UNLOAD) ? MODE_SHIFT :
                    (state == S_IDLE || state == S_DONE) ? MODE_NORM : MODE_RST;
  // Seed goes out MSB first as the counter walks N-1 down to 0.
  assign SDI = state == S_SEED && |((SEED >> cnt) & N'(1));
  assign sig_nxt = state == S_UNLOAD ? {SIG[N-2:0], SDO} :
                   (nxt == S_SEED && state != S_SEED) ? {N{1'b0}} : SIG;
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= S_IDLE;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      PASS <= 1'b0;
      SIG <= '0;
    end else begin
      state <= nxt;
      BUSY <= nxt == S_SEED || nxt == S_RUN || nxt == S_UNLOAD;
      DONE <= nxt == S_DONE;
      PASS <= nxt == S_DONE && (state == S_DONE ? PASS : sig_nxt == GOLD);
      SIG <= sig_nxt;
    end
  end
endmodule

// File: tb/tb_bilbo_bist_ctl.sv
// tb_bilbo_bist_ctl: sequencer paired with a behavioural BILBO, passing and failing golden values
module tb_bilbo_bist_ctl;
  localparam logic [7:0] ZV = 8'h5A;
  function automatic logic [7:0] misr(input logic [7:0] s, input int n);
    logic [7:0] q;
    q = s;
    for (int i = 0; i < n; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]} ^ ZV;
    return q;
  endfunction
  localparam logic [7:0] GOK = misr(8'hA5, 4);
  function automatic logic [7:0] bilbo(input logic [7:0] q, input logic [1:0] m, input logic sdi);
    return m == 2'b11 ? ZV : m == 2'b00 ? {q[6:0], sdi} : m == 2'b10 ? misr(q, 1) : 8'h00;
  endfunction
  logic CLK = 1'b0, CLR, START;
  logic B1_p, B2_p, SDI_p, BUSY_p, DONE_p, PASS_p;
  logic B1_f, B2_f, SDI_f, BUSY_f, DONE_f, PASS_f;
  logic [7:0] SIG_p, SIG_f, q_p, q_f;
  logic [7:0] seed_v = 8'hA5;
  int n_chk = 0, n_fail = 0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) begin
    q_p <= bilbo(q_p, {B1_p, B2_p}, SDI_p);
    q_f <= bilbo(q_f, {B1_f, B2_f}, SDI_f);
  end
  bilbo_bist_ctl #(.N(8), .NPAT(4), .SEED(8'hA5), .GOLD(GOK)) u_p (
    .CLK(CLK), .CLR(CLR), .START(START), .SDO(q_p[7]), .B1(B1_p), .B2(B2_p), .SDI(SDI_p),
    .BUSY(BUSY_p), .DONE(DONE_p), .PASS(PASS_p), .SIG(SIG_p)
  );
  bilbo_bist_ctl #(.N(8), .NPAT(4), .SEED(8'hA5), .GOLD(GOK ^ 8'h01)) u_f (
    .CLK(CLK), .CLR(CLR), .START(START), .SDO(q_f[7]), .B1(B1_f), .B2(B2_f), .SDI(SDI_f),
    .BUSY(BUSY_f), .DONE(DONE_f), .PASS(PASS_f), .SIG(SIG_f)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_mode"}, {B1_p, B2_p}, 2'b11);
    chk({tag, "_sdi"}, SDI_p, 1'b0);
    chk({tag, "_busy"}, BUSY_p, 1'b0);
    chk({tag, "_done"}, DONE_p, 1'b0);
    chk({tag, "_pass"}, PASS_p, 1'b0);
    chk({tag, "_sig"}, SIG_p, 8'h00);
  endtask
  task automatic wait_done(input int c0, input int pk, input bit hold, output int lat);
    int c;
    c = c0;
    while (!DONE_p && c < 60) begin
      START = hold || c == pk;
      step();
      c++;
    end
    START = hold;
    lat = c;
  endtask
  task automatic launch();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: end of test not reached");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int lat;
    CLR = 1'b0;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset");
    CLR = 1'b1;
    repeat (5) step();
    chk_idle("post_reset");
    launch();
    for (int i = 0; i < 8; i++) begin
      chk("seed_sdi", SDI_p, seed_v[7-i]);
      chk("seed_mode", {B1_p, B2_p}, 2'b00);
      chk("seed_busy", BUSY_p, 1'b1);
      step();
    end
    chk("seed_loaded", q_p, 8'hA5);
    chk("run_mode", {B1_p, B2_p}, 2'b10);
    wait_done(8, int'($urandom_range(8, 11)), 1'b0, lat);
    chk("lat_pass", lat, 20);
    chk("pass_pass", PASS_p, 1'b1);
    chk("pass_sig", SIG_p, GOK);
    chk("pass_busy", BUSY_p, 1'b0);
    chk("pass_mode", {B1_p, B2_p}, 2'b11);
    chk("fail_done", DONE_f, 1'b1);
    chk("fail_pass", PASS_f, 1'b0);
    chk("fail_sig", SIG_f, GOK);
    chk("fail_busy", BUSY_f, 1'b0);
    repeat (int'($urandom_range(1, 4))) step();
    chk("hold_done", DONE_p, 1'b1);
    chk("hold_pass", PASS_p, 1'b1);
    chk("hold_sig", SIG_p, GOK);
    START = 1'b1;
    step();
    chk("restart_sig", SIG_p, 8'h00);
    chk("restart_busy", BUSY_p, 1'b1);
    chk("restart_done", DONE_p, 1'b0);
    chk("restart_pass", PASS_p, 1'b0);
    wait_done(0, -1, 1'b1, lat);
    chk("lat_restart", lat, 20);
    chk("restart_pass_end", PASS_p, 1'b1);
    chk("restart_sig_end", SIG_p, GOK);
    step();
    chk("relaunch_done", DONE_p, 1'b0);
    chk("relaunch_busy", BUSY_p, 1'b1);
    START = 1'b0;
    wait_done(0, -1, 1'b0, lat);
    chk("lat_relaunch", lat, 20);
    chk("relaunch_pass", PASS_p, 1'b1);
    repeat (int'($urandom_range(1, 5))) step();
    launch();
    repeat (9) step();
    chk("abort_run_mode", {B1_p, B2_p}, 2'b10);
    CLR = 1'b0;
    #1;
    chk_idle("abort_run");
    step();
    CLR = 1'b1;
    repeat (3) step();
    chk("abort_no_done", DONE_p, 1'b0);
    chk("abort_no_pass", PASS_p, 1'b0);
    launch();
    wait_done(0, -1, 1'b0, lat);
    chk("lat_after_abort", lat, 20);
    chk("after_abort_pass", PASS_p, 1'b1);
    chk("after_abort_sig", SIG_p, GOK);
    launch();
    repeat (int'($urandom_range(1, 19))) step();
    chk("abort_rnd_busy_before", BUSY_p, 1'b1);
    CLR = 1'b0;
    #1;
    chk_idle("abort_rnd");
    step();
    CLR = 1'b1;
    step();
    launch();
    wait_done(0, -1, 1'b0, lat);
    chk("lat_final", lat, 20);
    chk("final_pass", PASS_p, 1'b1);
    chk("final_fail_pass", PASS_f, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
